game_state_ctrl: RTL and testbench

//  Top-level game sequencer: produces game_state (INIT/START/END/RESET) consumed by the collision

---
 rtl/game_state_ctrl_pkg.sv | 23 ++
 rtl/game_state_ctrl_bcd_counter.sv | 54 +++++
 rtl/game_state_ctrl.sv | 138 +++++++++++++
 tb/tb_game_state_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// game_state_ctrl_pkg
// Shared definitions for the game sequencer: the 2-bit game state encoding
// that the collision detector and renderers decode, and a single-digit BCD
// increment helper used by the score counter.
// ---------------------------------------------------------------------------
package game_state_ctrl_pkg;

    localparam int GAME_STATE_W = 2;

    typedef enum logic [GAME_STATE_W-1:0] {
        GAME_INIT  = 2'd0,
        GAME_START = 2'd1,
        GAME_END   = 2'd2,
        GAME_RESET = 2'd3
    } gameState_t;

    // One BCD digit +1, 9 wraps to 0 (carry handled by the caller).
    function automatic logic [3:0] bcdDigitInc(input logic [3:0] digit);
        return (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/game_state_ctrl_bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Saturating packed-BCD up-counter. Digit 0 lives in value[3:0]. Once every
// digit reads 9 further increments are ignored instead of wrapping to zero.
// Ports:
//   clk    in  1           system clock
//   rst    in  1           asynchronous active-high reset, clears value
//   clr    in  1           synchronous clear, wins over inc
//   inc    in  1           add one (BCD ripple carry)
//   value  out 4*DIGITS    registered packed BCD count
// ---------------------------------------------------------------------------
module bcd_counter
    import game_state_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] value
);

    logic [DIGITS-1:0]   digitIsNine;
    logic [DIGITS-1:0]   carry;      // carry[gi] = "digit gi must step"
    logic [4*DIGITS-1:0] valueNext;
    logic                allNines;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : gDigit
            assign digitIsNine[gi]       = (value[4*gi +: 4] == 4'd9);
            assign valueNext[4*gi +: 4]  = carry[gi] ? bcdDigitInc(value[4*gi +: 4])
                                                     : value[4*gi +: 4];
            if (gi < DIGITS-1) begin : gCarry
                assign carry[gi+1] = carry[gi] & digitIsNine[gi];
            end
        end
    endgenerate

    // Suppressing the first carry at all-9s is what makes the count saturate.
    assign allNines = &digitIsNine;
    assign carry[0] = inc & ~allNines;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else begin
            value <= valueNext;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
// Top-level game sequencer. Walks INIT -> START -> END -> RESET -> START,
// scores one point every FRAMES_PER_POINT frames while playing, tracks the
// best score since reset and flags a new record for one clock.
// Ports:
//   clk         in  1                system clock
//   rst         in  1                asynchronous active-high reset
//   frame_tick  in  1                one-clk pulse per video frame
//   start_btn   in  1                debounced button level (1 = pressed)
//   isColision  in  1                sticky collision flag
//   game_state  out 2                INIT=0, START=1, END=2, RESET=3
//   score       out 4*SCORE_DIGITS   packed BCD score
//   high_score  out 4*SCORE_DIGITS   packed BCD best score since rst
//   new_record  out 1                1-clk pulse when high_score updates
// ---------------------------------------------------------------------------
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_POINT   = 6,
    parameter int END_LOCKOUT_FRAMES = 30,
    parameter int RESET_HOLD_FRAMES  = 2,
    parameter int SCORE_DIGITS       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_tick,
    input  logic                      start_btn,
    input  logic                      isColision,
    output logic [GAME_STATE_W-1:0]   game_state,
    output logic [4*SCORE_DIGITS-1:0] score,
    output logic [4*SCORE_DIGITS-1:0] high_score,
    output logic                      new_record
);

    localparam int DIV_W  = $clog2(FRAMES_PER_POINT + 1);
    localparam int LOCK_W = $clog2(END_LOCKOUT_FRAMES + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD_FRAMES + 1);

    gameState_t  state;
    logic        btnQ;
    logic [DIV_W-1:0]  divCnt;
    logic [LOCK_W-1:0] lockCnt;
    logic [HOLD_W-1:0] holdCnt;

    logic startPulse;
    logic pointTick;
    logic lockDone;
    logic holdDone;
    logic scoreClr;
    logic scoreInc;

    assign startPulse = start_btn & ~btnQ;
    assign pointTick  = frame_tick && (divCnt == DIV_W'(FRAMES_PER_POINT - 1));
    assign lockDone   = (lockCnt == LOCK_W'(END_LOCKOUT_FRAMES));
    // The tick that would bring the hold count to its limit is the one that leaves RESET.
    assign holdDone   = frame_tick && (holdCnt == HOLD_W'(RESET_HOLD_FRAMES - 1));

    // Score clears on every entry into START; a collision masks the wrapping tick.
    assign scoreClr = ((state == GAME_INIT) && startPulse) ||
                      ((state == GAME_RESET) && holdDone);
    assign scoreInc = (state == GAME_START) && !isColision && pointTick;

    bcd_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (scoreClr),
        .inc   (scoreInc),
        .value (score)
    );

    assign game_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= GAME_INIT;
            btnQ       <= 1'b0;
            divCnt     <= '0;
            lockCnt    <= '0;
            holdCnt    <= '0;
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            btnQ       <= start_btn;
            new_record <= 1'b0;
            case (state)
                GAME_INIT: begin
                    if (startPulse) begin
                        state   <= GAME_START;
                        divCnt  <= '0;
                        lockCnt <= '0;
                        holdCnt <= '0;
                    end
                end
                GAME_START: begin
                    if (isColision) begin
                        state   <= GAME_END;
                        divCnt  <= '0;
                        lockCnt <= '0;
                        holdCnt <= '0;
                        // Score is final on this edge; packed BCD compares like binary.
                        if (score > high_score) begin
                            high_score <= score;
                            new_record <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        divCnt <= pointTick ? '0 : divCnt + 1'b1;
                    end
                end
                GAME_END: begin
                    // Presses during lockout are simply lost: only a fresh edge after it counts.
                    if (lockDone && startPulse) begin
                        state   <= GAME_RESET;
                        divCnt  <= '0;
                        lockCnt <= '0;
                        holdCnt <= '0;
                    end else if (frame_tick && !lockDone) begin
                        lockCnt <= lockCnt + 1'b1;
                    end
                end
                GAME_RESET: begin
                    if (holdDone) begin
                        state   <= GAME_START;
                        divCnt  <= '0;
                        lockCnt <= '0;
                        holdCnt <= '0;
                    end else if (frame_tick) begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                default: state <= GAME_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
// Self-checking bench: a vector table for the basic flow, then hand-written
// multi-cycle sequences (lockout, hold, scoring, records, async reset, held
// button) and a standalone saturation run of the BCD counter.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;
    import game_state_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic        isColision = 1'b0;
    logic [1:0]  game_state;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        new_record;

    logic        satRst = 1'b1;
    logic        satClr = 1'b0;
    logic        satInc = 1'b0;
    logic [15:0] satValue;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    game_state_ctrl #(
        .FRAMES_PER_POINT   (6),
        .END_LOCKOUT_FRAMES (30),
        .RESET_HOLD_FRAMES  (2),
        .SCORE_DIGITS       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .isColision (isColision),
        .game_state (game_state),
        .score      (score),
        .high_score (high_score),
        .new_record (new_record)
    );

    bcd_counter #(.DIGITS(4)) u_sat (
        .clk   (clk),
        .rst   (satRst),
        .clr   (satClr),
        .inc   (satInc),
        .value (satValue)
    );

    typedef struct {
        logic r, b, t, c;
        logic [1:0]  st;
        logic [15:0] sc, hs;
        logic        nr;
    } vec_t;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [15:0] sc, hs;
        logic        nr;
    } exp_t;

    exp_t expQ[$];
    vec_t vecs[16];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expectNext(input string name, input logic [1:0] st,
                              input logic [15:0] sc, input logic [15:0] hs, input logic nr);
        exp_t e;
        e.name = name; e.st = st; e.sc = sc; e.hs = hs; e.nr = nr;
        expQ.push_back(e);
    endtask

    task automatic popCheck();
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            $display("[TB] %s: state=%0d score=%04h high=%04h rec=%0b", e.name,
                     game_state, score, high_score, new_record);
            check({e.name, ".state"}, 32'(game_state), 32'(e.st));
            check({e.name, ".score"}, 32'(score), 32'(e.sc));
            check({e.name, ".high"},  32'(high_score), 32'(e.hs));
            check({e.name, ".rec"},   32'(new_record), 32'(e.nr));
        end
    endtask

    // Drive one cycle of inputs, then compare any expectation queued for this edge.
    task automatic cyc(input logic b, input logic t, input logic c);
        start_btn  = b;
        frame_tick = t;
        isColision = c;
        @(posedge clk);
        #1;
        popCheck();
    endtask

    task automatic ticks(input int n, input logic c);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, c);
    endtask

    // From END (collision still asserted): ride out the lockout, press, hold, back to START.
    task automatic restart(input string name, input logic [15:0] frozenScore, input logic [15:0] expHigh);
        ticks(30, 1'b1);
        expectNext({name, "_to_reset"}, GAME_RESET, frozenScore, expHigh, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        expectNext({name, "_hold1"}, GAME_RESET, frozenScore, expHigh, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        expectNext({name, "_to_start"}, GAME_START, 16'h0000, expHigh, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int edges;
        logic [1:0] prevState;

        // ---------------- BCD counter saturation ----------------
        @(posedge clk); #1;
        satRst = 1'b0;
        check("sat_reset", 32'(satValue), 32'h0);
        satInc = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("sat_carry_10", 32'(satValue), 32'h0010);
        repeat (9989) begin @(posedge clk); #1; end
        check("sat_reach_9999", 32'(satValue), 32'h9999);
        repeat (6) begin @(posedge clk); #1; end
        check("sat_hold_9999", 32'(satValue), 32'h9999);
        satInc = 1'b0;
        satClr = 1'b1;
        @(posedge clk); #1;
        check("sat_clear", 32'(satValue), 32'h0);
        satClr = 1'b0;

        // ---------------- table-driven basic flow ----------------
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, GAME_INIT,  16'h0, 16'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, GAME_INIT,  16'h0, 16'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, GAME_INIT,  16'h0, 16'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, GAME_INIT,  16'h0, 16'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, GAME_START, 16'h0, 16'h0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, GAME_START, 16'h0, 16'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, GAME_START, 16'h0, 16'h0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, GAME_START, 16'h0, 16'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, GAME_START, 16'h0, 16'h0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, GAME_START, 16'h0, 16'h0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, GAME_START, 16'h1, 16'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, GAME_START, 16'h1, 16'h0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, GAME_END,   16'h1, 16'h1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, GAME_END,   16'h1, 16'h1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, GAME_END,   16'h1, 16'h1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, GAME_END,   16'h1, 16'h1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].r;
            expectNext($sformatf("vec%0d", i), vecs[i].st, vecs[i].sc, vecs[i].hs, vecs[i].nr);
            cyc(vecs[i].b, vecs[i].t, vecs[i].c);
        end

        // ---------------- END lockout ----------------
        ticks(10, 1'b1);
        expectNext("press_at_tick10", GAME_END, 16'h1, 16'h1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        ticks(19, 1'b1);
        expectNext("press_at_tick29", GAME_END, 16'h1, 16'h1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        expectNext("held_through_tick30", GAME_END, 16'h1, 16'h1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        expectNext("held_after_lockout", GAME_END, 16'h1, 16'h1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        expectNext("fresh_press_to_reset", GAME_RESET, 16'h1, 16'h1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);

        // ---------------- RESET hold ----------------
        expectNext("hold_tick1", GAME_RESET, 16'h1, 16'h1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        expectNext("hold_press_ignored", GAME_RESET, 16'h1, 16'h1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        expectNext("hold_done_start", GAME_START, 16'h0, 16'h1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);

        // ---------------- game 2: score 17, new record ----------------
        ticks(18, 1'b0);
        expectNext("score_after_18", GAME_START, 16'h0003, 16'h1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        ticks(84, 1'b0);
        expectNext("score_bcd_17", GAME_START, 16'h0017, 16'h1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        ticks(5, 1'b0);
        expectNext("collide_on_wrap_tick", GAME_END, 16'h0017, 16'h0017, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        expectNext("record_pulse_ends", GAME_END, 16'h0017, 16'h0017, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        restart("g2", 16'h0017, 16'h0017);

        // ---------------- game 3: score 42 beats 17 ----------------
        ticks(252, 1'b0);
        expectNext("score_bcd_42", GAME_START, 16'h0042, 16'h0017, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        expectNext("record_42", GAME_END, 16'h0042, 16'h0042, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        expectNext("record_42_pulse_ends", GAME_END, 16'h0042, 16'h0042, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        restart("g3", 16'h0042, 16'h0042);

        // ---------------- game 4: low score, no record ----------------
        ticks(30, 1'b0);
        expectNext("score_5", GAME_START, 16'h0005, 16'h0042, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        expectNext("low_end_no_record", GAME_END, 16'h0005, 16'h0042, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        expectNext("low_end_still_no_record", GAME_END, 16'h0005, 16'h0042, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        restart("g4", 16'h0005, 16'h0042);

        // ---------------- asynchronous reset mid-START ----------------
        ticks(72, 1'b0);
        expectNext("score_12", GAME_START, 16'h0012, 16'h0042, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        expectNext("async_rst", GAME_INIT, 16'h0, 16'h0, 1'b0);
        popCheck();
        expectNext("rst_held", GAME_INIT, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        rst = 1'b0;

        // ---------------- button held 100 clocks in INIT ----------------
        edges = 0;
        prevState = game_state;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (prevState == GAME_INIT && game_state == GAME_START) edges++;
            prevState = game_state;
        end
        check("held_btn_start_edges", 32'(edges), 32'd1);
        check("held_btn_stays_start", 32'(game_state), 32'(GAME_START));
        expectNext("zero_score_end", GAME_END, 16'h0, 16'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
